// File: rtl/pong_pkg.sv
// Shared encodings and widths for the Pong match controller.
// Pure definitions: no latency or flow control of its own.
package pong_pkg;

    localparam int DIGIT_W = 4;
    localparam int SCORE_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// M:SS BCD countdown: load/dec take effect on the next edge, at_zero is combinational.
// No backpressure; dec at 0:00 is ignored so the clock never underflows.
module bcd_countdown
    import pong_pkg::*;
#(
    parameter int MATCH_MIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    output logic [DIGIT_W-1:0] min,
    output logic [DIGIT_W-1:0] sec1,
    output logic [DIGIT_W-1:0] sec2,
    output logic               at_zero
);

    localparam logic [DIGIT_W-1:0] MIN_INIT = DIGIT_W'(MATCH_MIN);

    assign at_zero = (min == '0) && (sec1 == '0) && (sec2 == '0);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            min  <= MIN_INIT;
            sec1 <= '0;
            sec2 <= '0;
        end else if (dec && !at_zero) begin
            if (sec2 != '0) begin
                sec2 <= sec2 - 1'b1;
            end else begin
                sec2 <= 4'd9;
                // Borrow ripples from units into tens, then tens into minutes.
                if (sec1 != '0) begin
                    sec1 <= sec1 - 1'b1;
                end else begin
                    sec1 <= 4'd5;
                    min  <= min - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pong_match_sequencer.sv
// Match FSM (IDLE/SERVE/PLAY/OVER) owning scores, serve delay and the match clock.
// Events act on the next edge; no backpressure, pulses arriving in a state that ignores them are dropped.
module pong_match_sequencer
    import pong_pkg::*;
#(
    parameter int MATCH_MIN   = 2,
    parameter int SCORE_MAX   = 7,
    parameter int SERVE_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               start,
    input  logic               miss1,
    input  logic               miss2,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [DIGIT_W-1:0] min,
    output logic [DIGIT_W-1:0] sec1,
    output logic [DIGIT_W-1:0] sec2,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] SMAX       = SCORE_W'(SCORE_MAX);
    localparam logic [2:0]         SERVE_INIT = 3'(SERVE_TICKS);

    logic [1:0]         next_state;
    logic               start_q;
    logic               start_hold;
    logic               start_pulse;
    logic [2:0]         serve_cnt;
    logic               at_zero;
    logic               one_left;
    logic               expire;
    logic               dec;
    logic               load;
    logic               any_miss;
    logic               score_end;
    logic [SCORE_W-1:0] s1_nxt;
    logic [SCORE_W-1:0] s2_nxt;

    // start_hold masks a start level that was already high during reset.
    assign start_pulse = start && !start_q && !start_hold;
    assign any_miss    = miss1 || miss2;
    assign s1_nxt      = miss2 ? sat_inc(score1) : score1;
    assign s2_nxt      = miss1 ? sat_inc(score2) : score2;
    assign score_end   = (s1_nxt >= SMAX) || (s2_nxt >= SMAX);
    assign dec         = tick_1hz && (state == ST_PLAY);
    assign one_left    = (min == '0) && (sec1 == '0) && (sec2 == 4'd1);
    assign expire      = (state == ST_PLAY) && (at_zero || (tick_1hz && one_left));
    assign load        = (next_state == ST_IDLE);

    bcd_countdown #(
        .MATCH_MIN (MATCH_MIN)
    ) u_clock (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .dec     (dec),
        .min     (min),
        .sec1    (sec1),
        .sec2    (sec2),
        .at_zero (at_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:  next_state = start_pulse ? ST_SERVE : ST_IDLE;
            ST_SERVE: next_state = (tick_1hz && serve_cnt == 3'd1) ? ST_PLAY : ST_SERVE;
            ST_PLAY: begin
                if (any_miss)    next_state = (score_end || expire) ? ST_OVER : ST_SERVE;
                else if (expire) next_state = ST_OVER;
                else             next_state = ST_PLAY;
            end
            ST_OVER:  next_state = start_pulse ? ST_IDLE : ST_OVER;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ball_run = (state == ST_PLAY);
        winner   = WIN_NONE;
        if (state == ST_OVER) begin
            if (score1 > score2)      winner = WIN_P1;
            else if (score2 > score1) winner = WIN_P2;
            else                      winner = WIN_DRAW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= 1'b0;
            start_hold <= start;
            ball_reset <= 1'b0;
            serve_cnt  <= '0;
            score1     <= '0;
            score2     <= '0;
            serve_dir  <= 1'b0;
        end else begin
            start_q    <= start;
            start_hold <= start_hold && start;
            ball_reset <= (next_state == ST_SERVE) && (state != ST_SERVE);

            if (next_state == ST_SERVE && state != ST_SERVE)
                serve_cnt <= SERVE_INIT;
            else if (state == ST_SERVE && tick_1hz && serve_cnt != 3'd1)
                serve_cnt <= serve_cnt - 1'b1;

            if (next_state == ST_IDLE) begin
                score1    <= '0;
                score2    <= '0;
                serve_dir <= 1'b0;
            end else if (state == ST_PLAY) begin
                score1 <= s1_nxt;
                score2 <= s2_nxt;
                // Serve goes toward whoever lost the point; a double miss flips it.
                if (miss1 && miss2) serve_dir <= !serve_dir;
                else if (miss1)     serve_dir <= 1'b0;
                else if (miss2)     serve_dir <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed bench for pong_match_sequencer with hand-computed expectations.
module tb_pong_match_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       start = 1'b0;
    logic       miss1 = 1'b0;
    logic       miss2 = 1'b0;
    logic [1:0] state;
    logic [2:0] score1, score2;
    logic [3:0] min, sec1, sec2;
    logic       ball_run, ball_reset, serve_dir;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_bad = 0;

    pong_match_sequencer #(
        .MATCH_MIN   (2),
        .SCORE_MAX   (7),
        .SERVE_TICKS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .start      (start),
        .miss1      (miss1),
        .miss2      (miss2),
        .state      (state),
        .score1     (score1),
        .score2     (score2),
        .min        (min),
        .sec1       (sec1),
        .sec2       (sec2),
        .ball_run   (ball_run),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    task automatic do_miss(input logic m1, input logic m2);
        miss1 = m1;
        miss2 = m2;
        step();
        miss1 = 1'b0;
        miss2 = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    function automatic logic [15:0] timer_now();
        return {4'h0, min, sec1, sec2};
    endfunction

    initial begin
        // Reset values
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("rst_state", state, 0);
        check_eq("rst_scores", {score1, score2}, 0);
        check_eq("rst_timer", timer_now(), 16'h0200);
        check_eq("rst_run_reset_dir", {ball_run, ball_reset, serve_dir}, 0);
        check_eq("rst_winner", winner, 0);

        // Start -> SERVE with one-cycle ball_reset, two serve ticks -> PLAY
        start = 1'b1;
        step();
        check_eq("serve_entry", state, 1);
        check_eq("serve_ball_reset", ball_reset, 1);
        start = 1'b0;
        step();
        check_eq("ball_reset_single", ball_reset, 0);
        pulse_tick();
        check_eq("serve_after_1tick", state, 1);
        check_eq("serve_run_low", ball_run, 0);
        pulse_tick();
        check_eq("play_entry", state, 2);
        check_eq("play_run", ball_run, 1);
        check_eq("play_timer_frozen", timer_now(), 16'h0200);

        // BCD countdown with borrows
        pulse_tick();
        check_eq("timer_159", timer_now(), 16'h0159);
        ticks(59);
        check_eq("timer_100", timer_now(), 16'h0100);
        pulse_tick();
        check_eq("timer_059", timer_now(), 16'h0059);

        // Double miss from 0-0
        do_miss(1'b1, 1'b1);
        check_eq("dbl_scores", {score1, score2}, 16'h0009);
        check_eq("dbl_dir", serve_dir, 1);
        check_eq("dbl_state", state, 1);
        check_eq("dbl_ball_reset", ball_reset, 1);
        // Miss during SERVE is ignored
        do_miss(1'b1, 1'b0);
        check_eq("serve_miss_ignored", score2, 1);
        ticks(2);
        check_eq("serve_timer_frozen", timer_now(), 16'h0059);

        // Player 1 climbs to 6, then the winning point
        do_miss(1'b1, 1'b0);
        check_eq("miss1_dir", serve_dir, 0);
        check_eq("miss1_score2", score2, 2);
        ticks(2);
        do_miss(1'b0, 1'b1);
        check_eq("miss2_dir", serve_dir, 1);
        check_eq("miss2_score1", score1, 2);
        ticks(2);
        for (int i = 0; i < 4; i++) begin
            do_miss(1'b0, 1'b1);
            ticks(2);
        end
        check_eq("score1_six", score1, 6);
        check_eq("still_play", state, 2);
        do_miss(1'b0, 1'b1);
        check_eq("win_score1", score1, 7);
        check_eq("win_state_over", state, 3);
        check_eq("win_run_low", ball_run, 0);
        check_eq("win_winner_p1", winner, 1);
        pulse_tick();
        check_eq("over_timer_held", timer_now(), 16'h0059);

        // OVER -> IDLE, held start does not immediately begin a new match
        start = 1'b1;
        step();
        check_eq("over_to_idle", state, 0);
        check_eq("idle_scores_clr", {score1, score2}, 0);
        check_eq("idle_timer_load", timer_now(), 16'h0200);
        step();
        step();
        check_eq("idle_needs_new_edge", state, 0);
        start = 1'b0;
        step();
        press_start();
        check_eq("second_start", state, 1);
        ticks(2);

        // 3-3 then expiry coinciding with a miss
        for (int i = 0; i < 3; i++) begin
            do_miss(1'b1, 1'b1);
            ticks(2);
        end
        check_eq("three_all", {score1, score2}, 16'h001b);
        check_eq("three_dir", serve_dir, 1);
        ticks(119);
        check_eq("timer_001", timer_now(), 16'h0001);
        check_eq("play_at_001", state, 2);
        tick_1hz = 1'b1;
        do_miss(1'b1, 1'b0);
        tick_1hz = 1'b0;
        check_eq("exp_score2", score2, 4);
        check_eq("exp_timer", timer_now(), 16'h0000);
        check_eq("exp_state", state, 3);
        check_eq("exp_winner_p2", winner, 2);

        // New match to 2-5 at 0:37, then reset with start held high
        press_start();
        step();
        check_eq("restart_idle", state, 0);
        press_start();
        ticks(2);
        for (int i = 0; i < 2; i++) begin
            do_miss(1'b0, 1'b1);
            ticks(2);
        end
        for (int i = 0; i < 5; i++) begin
            do_miss(1'b1, 1'b0);
            ticks(2);
        end
        ticks(83);
        check_eq("pre_rst_scores", {score1, score2}, 16'h0015);
        check_eq("pre_rst_timer", timer_now(), 16'h0037);
        check_eq("pre_rst_state", state, 2);
        rst = 1'b1;
        start = 1'b1;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check_eq("mid_rst_state", state, 0);
        check_eq("mid_rst_scores", {score1, score2}, 0);
        check_eq("mid_rst_timer", timer_now(), 16'h0200);
        check_eq("mid_rst_flags", {ball_run, ball_reset, serve_dir, winner}, 0);
        rst = 1'b0;
        step();
        step();
        check_eq("held_start_no_match", state, 0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check_eq("fresh_edge_starts", state, 1);
        start = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
